// File: rtl/led_pkg.sv
// Shared constants and serial-refresh state encoding for the LED controller.
package led_pkg;

  localparam int NUM_PORTS       = 8;
  localparam int TICK_DIV_DEF    = 50000;
  localparam int BLINK_TICKS_DEF = 250;
  localparam int ACT_TICKS_DEF   = 40;
  localparam int SHIFT_DIV_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } ser_state_t;

endpackage

// File: rtl/led_stretch.sv
// Per-port activity stretcher: a raw pulse holds act high for ACT_TICKS timebase ticks.
module led_stretch
  import led_pkg::*;
#(
  parameter int ACT_TICKS = ACT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic act_raw,
  output logic act
);

  localparam int CW = $clog2(ACT_TICKS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACT_TICKS);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // A new pulse always reloads the full count, even when it lands on a tick.
  always_comb begin
    cnt_next = cnt;
    if (act_raw) begin
      cnt_next = CNT_LOAD;
    end else if (tick && (cnt != '0)) begin
      cnt_next = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      act <= 1'b0;
    end else begin
      cnt <= cnt_next;
      act <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// LED controller: timebase, shared blink, per-port activity stretch and
// serial refresh of an external 8-bit LED shift register.
module led_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF,
  parameter int ACT_TICKS   = ACT_TICKS_DEF,
  parameter int SHIFT_DIV   = SHIFT_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] act_raw,
  input  logic [7:0] led_in,
  output logic       blink,
  output logic [7:0] act,
  output logic       led_sclk,
  output logic       led_sdata,
  output logic       led_latch,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int SW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] DIV_MAX   = SW'(SHIFT_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [BW-1:0] blink_cnt;

  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stretch
    led_stretch #(
      .ACT_TICKS(ACT_TICKS)
    ) u_stretch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .act_raw(act_raw[i]),
      .act    (act[i])
    );
  end

  ser_state_t    state;
  ser_state_t    state_next;
  logic [SW-1:0] div_cnt;
  logic [SW-1:0] div_next;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic [7:0]    shadow;
  logic [7:0]    shadow_next;
  logic          sclk_next;
  logic          sdata_next;
  logic          latch_next;
  logic          busy_next;
  logic          hold_done;

  assign hold_done = (div_cnt == DIV_MAX);

  // Outputs are computed alongside the next state so the registered pins line
  // up with the state they belong to; ticks outside IDLE are simply dropped.
  always_comb begin
    state_next  = state;
    div_next    = div_cnt;
    idx_next    = idx;
    shadow_next = shadow;
    sclk_next   = led_sclk;
    sdata_next  = led_sdata;
    latch_next  = led_latch;
    busy_next   = busy;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_next  = SHIFT_LO;
          shadow_next = led_in;
          idx_next    = 3'd7;
          div_next    = '0;
          sclk_next   = 1'b0;
          sdata_next  = led_in[7];
          latch_next  = 1'b0;
          busy_next   = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (hold_done) begin
          state_next = SHIFT_HI;
          div_next   = '0;
          sclk_next  = 1'b1;
        end else begin
          div_next = div_cnt + SW'(1);
        end
      end
      SHIFT_HI: begin
        if (hold_done) begin
          div_next  = '0;
          sclk_next = 1'b0;
          if (idx == 3'd0) begin
            state_next = LATCH;
            sdata_next = 1'b0;
            latch_next = 1'b1;
          end else begin
            state_next = SHIFT_LO;
            idx_next   = idx - 3'd1;
            sdata_next = shadow[idx - 3'd1];
          end
        end else begin
          div_next = div_cnt + SW'(1);
        end
      end
      LATCH: begin
        if (hold_done) begin
          state_next = IDLE;
          div_next   = '0;
          latch_next = 1'b0;
          busy_next  = 1'b0;
        end else begin
          div_next = div_cnt + SW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      idx       <= 3'd0;
      shadow    <= 8'h00;
      led_sclk  <= 1'b0;
      led_sdata <= 1'b0;
      led_latch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      div_cnt   <= div_next;
      idx       <= idx_next;
      shadow    <= shadow_next;
      led_sclk  <= sclk_next;
      led_sdata <= sdata_next;
      led_latch <= latch_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: behavioural model compared every cycle,
// plus directed literal checks on blink, stretch, frame content and reset abort.
module tb_led_ctrl;

  localparam int TD    = 10;
  localparam int BT    = 3;
  localparam int AT    = 2;
  localparam int SD    = 1;
  localparam int FRAME = 17 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] act_raw = 8'h00;
  logic [7:0] led_in = 8'h00;
  logic       blink;
  logic [7:0] act;
  logic       led_sclk;
  logic       led_sdata;
  logic       led_latch;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_ctrl #(
    .TICK_DIV   (TD),
    .BLINK_TICKS(BT),
    .ACT_TICKS  (AT),
    .SHIFT_DIV  (SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .act_raw  (act_raw),
    .led_in   (led_in),
    .blink    (blink),
    .act      (act),
    .led_sclk (led_sclk),
    .led_sdata(led_sdata),
    .led_latch(led_latch),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] l);
    act_raw = a;
    led_in  = l;
  endtask

  // Model state: edge count since release, last pulse edge per port, frame start and content.
  int         m_cyc;
  logic [7:0] m_has;
  int         m_last[8];
  logic       m_fvalid;
  int         m_fstart;
  logic [7:0] m_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc    = 0;
      m_has    = 8'h00;
      m_fvalid = 1'b0;
      m_fstart = 0;
      m_frame  = 8'h00;
      for (int i = 0; i < 8; i++) m_last[i] = 0;
    end else begin
      m_cyc++;
      for (int i = 0; i < 8; i++) begin
        if (act_raw[i]) begin
          m_has[i]  = 1'b1;
          m_last[i] = m_cyc;
        end
      end
      if ((m_cyc % TD) == 0 && (!m_fvalid || (m_cyc - m_fstart) >= FRAME + 1)) begin
        m_fvalid = 1'b1;
        m_fstart = m_cyc;
        m_frame  = led_in;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0]  ea;
    logic        eb, esclk, esdata, elatch, ebusy;
    logic [11:0] expv, got;
    int          k, phase;
    for (int i = 0; i < 8; i++)
      ea[i] = m_has[i] && (((m_cyc / TD) - (m_last[i] / TD)) < AT);
    eb     = ((m_cyc / (TD * BT)) % 2) == 1;
    esclk  = 1'b0;
    esdata = 1'b0;
    elatch = 1'b0;
    ebusy  = 1'b0;
    if (m_fvalid) begin
      k = m_cyc - m_fstart;
      if (k < 16 * SD) begin
        phase  = k / SD;
        esclk  = (phase % 2) == 1;
        esdata = m_frame[7 - phase / 2];
        ebusy  = 1'b1;
      end else if (k < FRAME) begin
        elatch = 1'b1;
        ebusy  = 1'b1;
      end
    end
    expv = {eb, ea, esclk, esdata, elatch, ebusy};
    got  = {blink, act, led_sclk, led_sdata, led_latch, busy};
    checkOutput("model_cmp", {20'd0, got}, {20'd0, expv});
  end

  logic cap_q[$];
  int   latch_cycles = 0;
  int   busy_cycles = 0;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (led_sclk && !prev_sclk) cap_q.push_back(led_sdata);
    if (led_latch) latch_cycles++;
    if (busy) busy_cycles++;
    prev_sclk = led_sclk;
  end

  task automatic clearCapture();
    cap_q.delete();
    latch_cycles = 0;
    busy_cycles  = 0;
  endtask

  task automatic checkFrame(input string name, input logic [7:0] expv);
    logic [7:0] b;
    b = 8'h00;
    checkOutput({name, "_len"}, cap_q.size(), 8);
    foreach (cap_q[j]) b = {b[6:0], cap_q[j]};
    checkOutput({name, "_bits"}, {24'd0, b}, {24'd0, expv});
    checkOutput({name, "_latch"}, latch_cycles, 1);
    checkOutput({name, "_busy"}, busy_cycles, FRAME);
  endtask

  task automatic stepTo(input int target);
    int guard;
    guard = 0;
    while (m_cyc < target && guard < 1000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (m_cyc != target) checkOutput("step_sync", m_cyc, target);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(8'h00, 8'h00);
    rst_n = 1'b0;
    #23;
    checkOutput("reset_outputs", {20'd0, blink, act, led_sclk, led_sdata, led_latch, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    stepTo(29);
    checkOutput("blink_before_rise", blink, 0);
    stepTo(30);
    checkOutput("blink_first_rise", blink, 1);

    applyStimulus(8'h08, 8'h00);
    stepTo(31);
    applyStimulus(8'h00, 8'h00);
    checkOutput("act3_rise", act, 8'h08);
    stepTo(49);
    checkOutput("act3_held", act, 8'h08);
    stepTo(50);
    checkOutput("act3_fall", act, 8'h00);

    stepTo(68);
    clearCapture();
    applyStimulus(8'h00, 8'hA5);
    stepTo(73);
    applyStimulus(8'h00, 8'h00);
    stepTo(88);
    checkFrame("frame_a5", 8'hA5);
    clearCapture();
    stepTo(108);
    checkFrame("frame_00", 8'h00);

    stepTo(110);
    applyStimulus(8'h01, 8'h00);
    stepTo(111);
    applyStimulus(8'h00, 8'h00);
    checkOutput("act0_rise", act, 8'h01);
    stepTo(128);
    applyStimulus(8'h01, 8'h00);
    stepTo(129);
    applyStimulus(8'h00, 8'h00);
    stepTo(130);
    checkOutput("act0_retrig_hold", act[0], 1);
    stepTo(139);
    checkOutput("act0_retrig_late", act[0], 1);
    stepTo(140);
    checkOutput("act0_retrig_fall", act[0], 0);

    stepTo(141);
    applyStimulus(8'h00, 8'hA5);
    stepTo(157);
    checkOutput("pre_reset_sclk", led_sclk, 1);
    clearCapture();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_abort", {20'd0, blink, act, led_sclk, led_sdata, led_latch, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("no_latch_on_abort", latch_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clearCapture();
    applyStimulus(8'h00, 8'h3C);
    stepTo(28);
    checkFrame("frame_after_reset", 8'h3C);

    repeat (400) begin
      @(posedge clk);
      #2;
      applyStimulus(8'($urandom) & 8'($urandom) & 8'($urandom), 8'($urandom));
    end
    applyStimulus(8'h00, 8'h00);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per timebase tick (1 kHz at 50 MHz).
REQ-002 Parameter BLINK_TICKS, default 250, ticks per blink half-period.
REQ-003 Parameter ACT_TICKS, default 40, ticks an activity indication is stretched.
REQ-004 Parameter SHIFT_DIV, default 4, clk cycles per serial clock half-period; the block SHALL require TICK_DIV > 17*SHIFT_DIV.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 act_raw  in  8  per-port raw activity pulses from the MACs, one bit per port.
REQ-008 led_in  in  8  per-port LED states from the LED drivers, bit i = port i.
REQ-009 blink  out  1  shared blink pattern to the LED drivers.
REQ-010 act  out  8  stretched per-port activity to the LED drivers.
REQ-011 led_sclk  out  1  serial clock to the external LED shift register, idle low.
REQ-012 led_sdata  out  1  serial data, MSB (port 7) first.
REQ-013 led_latch  out  1  storage-register latch pulse, active high.
REQ-014 busy  out  1  high while a serial refresh is in progress.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and emit a one-cycle internal tick on wrap; first tick at cycle TICK_DIV after reset release.
REQ-016 Blink counter SHALL advance on each tick over 0..BLINK_TICKS-1 and toggle blink on wrap; period = 2*BLINK_TICKS*TICK_DIV cycles.
REQ-017 Per port, act_raw[i]=1 SHALL load a stretch counter with ACT_TICKS; otherwise the counter SHALL decrement on tick while nonzero.
REQ-018 act[i] SHALL be registered (counter != 0), rising one cycle after the first act_raw[i] high cycle.
REQ-019 act_raw[i] coincident with tick SHALL reload (reload wins over decrement); act_raw[i] held high SHALL keep act[i]=1.
REQ-020 A pulse arriving while act[i]=1 SHALL retrigger to a full ACT_TICKS; counter SHALL never underflow below 0.
REQ-021 Serial FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-022 IDLE: on tick, capture led_in into a shadow register, load bit index 7, go SHIFT_LO, busy=1 from next cycle.
REQ-023 SHIFT_LO: led_sclk=0, led_sdata=shadow[index], hold SHIFT_DIV cycles, go SHIFT_HI.
REQ-024 SHIFT_HI: led_sclk=1, led_sdata held, hold SHIFT_DIV cycles; if index=0 go LATCH, else decrement index and go SHIFT_LO.
REQ-025 LATCH: led_latch=1, led_sclk=0, hold SHIFT_DIV cycles, then IDLE with busy=0.
REQ-026 Refresh SHALL occupy exactly 17*SHIFT_DIV cycles; a tick arriving while not IDLE SHALL be ignored (no queueing).
REQ-027 led_in changes during a refresh SHALL NOT affect the frame in progress (shadow only).
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 rst_n low SHALL asynchronously force blink=0, act=0, led_sclk=0, led_sdata=0, led_latch=0, busy=0, FSM=IDLE, all counters and shadow=0.
REQ-030 Reset mid-refresh SHALL abort the frame immediately; no latch pulse SHALL be issued for it.
REQ-031 Release SHALL be effective on the first rising clk edge after rst_n goes high.

Structure
REQ-032 Shared package led_pkg SHALL hold the FSM state encoding and the parameter default constants.
REQ-033 Per-port stretcher SHALL be sub-module led_stretch (inputs clk, rst_n, tick, act_raw; output act), instantiated 8 times.

Verification (TICK_DIV=10, BLINK_TICKS=3, ACT_TICKS=2, SHIFT_DIV=1)
REQ-034 Reset release, idle inputs -> tick every 10 cycles; blink toggles every 30 cycles, first rise at cycle 30.
REQ-035 act_raw[3] one-cycle pulse -> act[3]=1 next cycle, falls at the second following tick; other act bits stay 0.
REQ-036 act_raw[0] pulse, second pulse one cycle before the second tick -> act[0] extended to a full 2 ticks from the retrigger.
REQ-037 led_in=8'hA5 at a tick -> sdata sequence 1,0,1,0,0,1,0,1 sampled on sclk rises, one-cycle latch, busy high 17 cycles.
REQ-038 led_in changed to 8'h00 mid-frame -> frame still shifts 8'hA5; next tick shifts 8'h00.
REQ-039 rst_n low during SHIFT_HI of bit 4 -> all outputs 0 at once, no latch; normal frame at next tick after release.
